// File: rtl/vx_mem_ahb_bridge_if.sv
// AHB-Lite manager/subordinate bundle used by the Vortex memory bridge.
`timescale 1ns/1ps
interface ahb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      HSEL;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic                      HMASTLOCK;
  logic [ADDR_WIDTH-1:0]     HADDR;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic [DATA_WIDTH/8-1:0]   HWSTRB;
  logic                      HREADY;
  logic                      HRESP;
  logic [DATA_WIDTH-1:0]     HRDATA;

  modport manager (
    output HSEL, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HADDR, HWDATA, HWSTRB,
    input  HREADY, HRESP, HRDATA
  );

  modport subordinate (
    input  HSEL, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HADDR, HWDATA, HWSTRB,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/vx_mem_ahb_bridge.sv
// Vortex line-request to AHB-Lite bridge: each line is split into single
// NONSEQ word transfers; write beats with no byte enables are skipped.
`timescale 1ns/1ps
module vx_mem_ahb_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int VX_DATA_WIDTH = 512,
  parameter int VX_ADDR_WIDTH = 26,
  parameter int VX_TAG_WIDTH  = 56
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       Vortex_mem_req_valid,
  input  logic                       Vortex_mem_req_rw,
  input  logic [VX_DATA_WIDTH/8-1:0] Vortex_mem_req_byteen,
  input  logic [VX_ADDR_WIDTH-1:0]   Vortex_mem_req_addr,
  input  logic [VX_DATA_WIDTH-1:0]   Vortex_mem_req_data,
  input  logic [VX_TAG_WIDTH-1:0]    Vortex_mem_req_tag,
  output logic                       Vortex_mem_req_ready,
  output logic                       Vortex_mem_rsp_valid,
  output logic [VX_DATA_WIDTH-1:0]   Vortex_mem_rsp_data,
  output logic [VX_TAG_WIDTH-1:0]    Vortex_mem_rsp_tag,
  input  logic                       Vortex_mem_rsp_ready,
  ahb_if.manager                     ahbif,
  output logic                       bus_error
);
  localparam int unsigned NBEATS     = VX_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned BW         = $clog2(NBEATS);
  localparam int unsigned BPB        = DATA_WIDTH / 8;
  localparam int unsigned LINE_SHIFT = $clog2(VX_DATA_WIDTH / 8);
  localparam logic [2:0]  SIZE       = 3'($clog2(BPB));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

  state_t                     r_state;
  logic [BW-1:0]              r_beat;
  logic                       r_rw;
  logic [VX_DATA_WIDTH/8-1:0] r_byteen;
  logic [VX_ADDR_WIDTH-1:0]   r_addr;
  logic [VX_DATA_WIDTH-1:0]   r_data;
  logic [VX_DATA_WIDTH-1:0]   r_line;
  logic [VX_TAG_WIDTH-1:0]    r_tag;
  logic                       r_hsel;
  logic [1:0]                 r_htrans;
  logic                       r_hwrite;
  logic [2:0]                 r_hsize;
  logic [ADDR_WIDTH-1:0]      r_haddr;
  logic [DATA_WIDTH-1:0]      r_hwdata;
  logic [BPB-1:0]             r_hwstrb;
  logic                       r_bus_error;

  logic                       w_tgt_ok;
  logic [BW-1:0]              w_tgt_beat;
  logic [ADDR_WIDTH-1:0]      w_base;
  logic [ADDR_WIDTH-1:0]      w_tgt_addr;

  // Next beat to put on the bus: from IDLE it is chosen from the incoming
  // request, from DATA from the latched one. Writes jump straight over beats
  // with an all-zero strobe slice so skipped beats cost no cycles.
  always_comb begin
    w_tgt_ok   = 1'b0;
    w_tgt_beat = '0;
    w_base     = '0;
    if (r_state == IDLE) begin
      w_base = ADDR_WIDTH'({Vortex_mem_req_addr, {LINE_SHIFT{1'b0}}});
      if (!Vortex_mem_req_rw) begin
        w_tgt_ok = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NBEATS; i++) begin
          if (!w_tgt_ok && (|Vortex_mem_req_byteen[i*BPB +: BPB])) begin
            w_tgt_ok   = 1'b1;
            w_tgt_beat = BW'(i);
          end
        end
      end
    end else begin
      w_base = ADDR_WIDTH'({r_addr, {LINE_SHIFT{1'b0}}});
      if (!r_rw) begin
        w_tgt_ok   = (r_beat != BW'(NBEATS - 1));
        w_tgt_beat = r_beat + 1'b1;
      end else begin
        for (int unsigned i = 0; i < NBEATS; i++) begin
          if (!w_tgt_ok && (i > 32'(r_beat)) && (|r_byteen[i*BPB +: BPB])) begin
            w_tgt_ok   = 1'b1;
            w_tgt_beat = BW'(i);
          end
        end
      end
    end
    w_tgt_addr = w_base + (ADDR_WIDTH'(w_tgt_beat) << $clog2(BPB));
  end

  // Request/beat sequencing with all bus outputs registered on transitions.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_rw        <= 1'b0;
      r_byteen    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_line      <= '0;
      r_tag       <= '0;
      r_hsel      <= 1'b0;
      r_htrans    <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_haddr     <= '0;
      r_hwdata    <= '0;
      r_hwstrb    <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Vortex_mem_req_valid) begin
            r_rw     <= Vortex_mem_req_rw;
            r_byteen <= Vortex_mem_req_byteen;
            r_addr   <= Vortex_mem_req_addr;
            r_data   <= Vortex_mem_req_data;
            r_tag    <= Vortex_mem_req_tag;
            r_line   <= '0;
            r_beat   <= w_tgt_beat;
            if (w_tgt_ok) begin
              r_state  <= ADDR;
              r_hsel   <= 1'b1;
              r_htrans <= 2'b10;
              r_hwrite <= Vortex_mem_req_rw;
              r_hsize  <= SIZE;
              r_haddr  <= w_tgt_addr;
            end
          end
        end
        ADDR: begin
          if (ahbif.HREADY) begin
            r_state  <= DATA;
            r_hsel   <= 1'b0;
            r_htrans <= '0;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_haddr  <= '0;
            r_hwdata <= r_data[r_beat*DATA_WIDTH +: DATA_WIDTH];
            r_hwstrb <= r_rw ? r_byteen[r_beat*BPB +: BPB] : '0;
          end
        end
        DATA: begin
          if (ahbif.HREADY) begin
            r_hwdata    <= '0;
            r_hwstrb    <= '0;
            r_bus_error <= ahbif.HRESP;
            if (!r_rw) begin
              r_line[r_beat*DATA_WIDTH +: DATA_WIDTH] <= ahbif.HRESP ? '0 : ahbif.HRDATA;
            end
            if (w_tgt_ok) begin
              r_state  <= ADDR;
              r_beat   <= w_tgt_beat;
              r_hsel   <= 1'b1;
              r_htrans <= 2'b10;
              r_hwrite <= r_rw;
              r_hsize  <= SIZE;
              r_haddr  <= w_tgt_addr;
            end else begin
              r_state <= r_rw ? IDLE : RSP;
            end
          end
        end
        RSP: begin
          if (Vortex_mem_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Vortex_mem_req_ready = (r_state == IDLE);
  assign Vortex_mem_rsp_valid = (r_state == RSP);
  assign Vortex_mem_rsp_data  = (r_state == RSP) ? r_line : '0;
  assign Vortex_mem_rsp_tag   = (r_state == RSP) ? r_tag  : '0;
  assign bus_error            = r_bus_error;

  assign ahbif.HSEL      = r_hsel;
  assign ahbif.HTRANS    = r_htrans;
  assign ahbif.HWRITE    = r_hwrite;
  assign ahbif.HSIZE     = r_hsize;
  assign ahbif.HBURST    = '0;
  assign ahbif.HMASTLOCK = 1'b0;
  assign ahbif.HADDR     = r_haddr;
  assign ahbif.HWDATA    = r_hwdata;
  assign ahbif.HWSTRB    = r_hwstrb;
endmodule

// File: tb/tb_vx_mem_ahb_bridge.sv
// Self-checking bench for vx_mem_ahb_bridge: an AHB subordinate model with
// programmable stall/error beat, and a line-level reference model.
`timescale 1ns/1ps
module tb_vx_mem_ahb_bridge;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_rw = 1'b0;
  logic [63:0]  req_byteen = '0;
  logic [25:0]  req_addr = '0;
  logic [511:0] req_data = '0;
  logic [55:0]  req_tag = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [511:0] rsp_data;
  logic [55:0]  rsp_tag;
  logic         rsp_ready = 1'b0;
  logic         bus_error;

  ahb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  vx_mem_ahb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .VX_DATA_WIDTH(512),
    .VX_ADDR_WIDTH(26), .VX_TAG_WIDTH(56)
  ) dut (
    .clk(clk), .nRST(nRST),
    .Vortex_mem_req_valid(req_valid), .Vortex_mem_req_rw(req_rw),
    .Vortex_mem_req_byteen(req_byteen), .Vortex_mem_req_addr(req_addr),
    .Vortex_mem_req_data(req_data), .Vortex_mem_req_tag(req_tag),
    .Vortex_mem_req_ready(req_ready), .Vortex_mem_rsp_valid(rsp_valid),
    .Vortex_mem_rsp_data(rsp_data), .Vortex_mem_rsp_tag(rsp_tag),
    .Vortex_mem_rsp_ready(rsp_ready), .ahbif(bus), .bus_error(bus_error)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Subordinate model configuration and capture.
  int          wait_beat = -1;
  int          waits_left = 0;
  int          err_beat = -1;
  logic [15:0] salt = '0;
  bit          dphase = 1'b0;
  logic [31:0] cap_addr;
  logic        cap_wr;
  logic [2:0]  cap_size;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;
  xfer_t q_xf[$];

  function automatic logic [31:0] rdgen(input logic [31:0] a, input logic [15:0] s);
    return {s, a[17:2]};
  endfunction

  // Subordinate: decides HREADY/HRESP/HRDATA at the falling edge for the next rising edge.
  always @(negedge clk) begin
    xfer_t x;
    if (!nRST) begin
      dphase = 1'b0;
      bus.HREADY <= 1'b1;
      bus.HRESP  <= 1'b0;
      bus.HRDATA <= '0;
    end else if (dphase) begin
      bus.HREADY <= 1'b1;
      bus.HRESP  <= (int'(cap_addr[5:2]) == err_beat);
      bus.HRDATA <= rdgen(cap_addr, salt);
      x.addr  = cap_addr;
      x.wr    = cap_wr;
      x.size  = cap_size;
      x.wdata = bus.HWDATA;
      x.strb  = bus.HWSTRB;
      q_xf.push_back(x);
      dphase = 1'b0;
    end else if (bus.HSEL && bus.HTRANS == 2'b10) begin
      bus.HRESP <= 1'b0;
      if (int'(bus.HADDR[5:2]) == wait_beat && waits_left > 0) begin
        bus.HREADY <= 1'b0;
        waits_left = waits_left - 1;
      end else begin
        bus.HREADY <= 1'b1;
        dphase   = 1'b1;
        cap_addr = bus.HADDR;
        cap_wr   = bus.HWRITE;
        cap_size = bus.HSIZE;
      end
    end else begin
      bus.HREADY <= 1'b1;
      bus.HRESP  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ahb_idle(input string tag);
    check(tag, {bus.HSEL, bus.HTRANS, bus.HADDR, bus.HWSTRB, bus.HWDATA}, '0);
  endtask

  // One full line request checked against the reference model.
  task automatic do_req(input logic rw, input logic [63:0] be, input logic [25:0] a,
                        input logic [511:0] d, input logic [55:0] t, input int wb,
                        input int wn, input int eb, input int hold, input logic [15:0] s);
    xfer_t        exp_q[$];
    xfer_t        x;
    xfer_t        act;
    logic [511:0] exp_line;
    logic [31:0]  base;
    logic [31:0]  prev_haddr;
    int           exp_lat, exp_err, exp_stall, errs, n_stall;
    int unsigned  hs;
    bit           done, prev_ap;
    base = {a, 6'b0};
    exp_line = '0;
    exp_lat = 0;
    exp_err = 0;
    exp_stall = 0;
    for (int b = 0; b < 16; b++) begin
      if (!rw || be[4*b +: 4] != 4'h0) begin
        x.addr  = base + 32'(4 * b);
        x.wr    = rw;
        x.size  = 3'b010;
        x.wdata = rw ? d[32*b +: 32] : 32'h0;
        x.strb  = rw ? be[4*b +: 4] : 4'h0;
        exp_q.push_back(x);
        exp_lat += 2;
        if (b == wb) begin
          exp_lat += wn;
          exp_stall = wn;
        end
        if (b == eb) exp_err = 1;
        if (!rw) exp_line[32*b +: 32] = (b == eb) ? 32'h0 : rdgen(x.addr, s);
      end
    end
    wait_beat = wb;
    waits_left = wn;
    err_beat = eb;
    salt = s;
    q_xf.delete();

    @(negedge clk);
    req_rw = rw; req_byteen = be; req_addr = a; req_data = d; req_tag = t;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_data = '0;
    req_byteen = '0;
    hs = cyc;
    done = 1'b0; prev_ap = 1'b0; prev_haddr = '0; errs = 0; n_stall = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (bus_error) errs++;
      if (prev_ap && !bus.HREADY) begin
        n_stall++;
        check("stall_htrans", bus.HTRANS, 2'b10);
        check("stall_haddr", bus.HADDR, prev_haddr);
      end
      prev_ap = bus.HSEL && bus.HTRANS == 2'b10;
      prev_haddr = bus.HADDR;
      if (rw ? (req_ready === 1'b1) : (rsp_valid === 1'b1)) done = 1'b1;
    end
    check("request_completes", done, 1'b1);
    if (!done) return;
    // Edges from the handshake edge to the first RSP/IDLE cycle; counting the
    // handshake cycle itself as cycle 1, a zero-wait read responds at cycle 33.
    check("latency", cyc - hs, exp_lat);
    check("stall_cycles", n_stall, exp_stall);
    if (!rw) begin
      check_ahb_idle("ahb_zero_in_rsp");
      for (int k = 0; k <= hold; k++) begin
        if (k > 0) @(negedge clk);
        if (bus_error) errs++;
        check("rsp_valid_held", rsp_valid, 1'b1);
        check("rsp_data", rsp_data, exp_line);
        check("rsp_tag", rsp_tag, t);
        if (k == hold) rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_after", rsp_valid, 1'b0);
      check("rsp_data_zero", rsp_data, '0);
      check("rsp_tag_zero", rsp_tag, '0);
      check("ready_after_rsp", req_ready, 1'b1);
    end else begin
      check("write_no_rsp", rsp_valid, 1'b0);
      check_ahb_idle("ahb_zero_after_write");
    end
    check("bus_error_pulses", errs, exp_err);
    check("xfer_count", q_xf.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_xf.size(); i++) begin
      act = q_xf[i];
      if (!rw) act.wdata = '0;
      check("xfer", act, exp_q[i]);
    end
  endtask

  logic [511:0] d_idx;
  logic [511:0] d_rnd;
  logic [63:0]  be_rnd;
  logic [55:0]  t_rnd;
  int           wb_r, eb_r;
  bit           found;

  initial begin
    for (int i = 0; i < 16; i++) d_idx[32*i +: 32] = 32'(i);

    // Reset values, both while held and just after release.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_bus_error", bus_error, 1'b0);
    check_ahb_idle("rst_ahb");
    nRST = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_rsp", {rsp_valid, rsp_data, rsp_tag}, '0);
    check_ahb_idle("post_rst_ahb");

    // Zero-wait read returning the beat index.
    do_req(1'b0, '0, 26'h3C00000, '0, 56'h5A, -1, 0, -1, 0, 16'h0000);
    // Sparse writes: two enabled beats each.
    do_req(1'b1, 64'h000F_0000_0000_00F0, 26'h3C00000, d_idx, 56'h1, -1, 0, -1, 0, 16'h0);
    do_req(1'b1, 64'hF000_0000_0000_00F0, 26'h3C00000, d_idx, 56'h2, -1, 0, -1, 0, 16'h0);
    // All-zero strobes: no transfer, back in IDLE immediately.
    do_req(1'b1, 64'h0, 26'h1234567, d_idx, 56'h3, -1, 0, -1, 0, 16'h0);
    // Three stall cycles on beat 5 and a four-cycle response back-pressure.
    do_req(1'b0, '0, 26'h0001000, '0, 56'hABCDEF, 5, 3, -1, 4, 16'h1111);
    // Error response on beat 2.
    do_req(1'b0, '0, 26'h0002000, '0, 56'h77, -1, 0, 2, 0, 16'h2222);

    // Reset in the middle of a read at beat 7.
    wait_beat = -1; waits_left = 0; err_beat = -1; salt = 16'h3333;
    @(negedge clk);
    req_rw = 1'b0; req_addr = 26'h0003000; req_tag = 56'h99; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (bus.HSEL && bus.HTRANS == 2'b10 && bus.HADDR == 32'h000C_001C) found = 1'b1;
    end
    check("reach_beat7", found, 1'b1);
    #1 nRST = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_rsp", {rsp_valid, rsp_data, rsp_tag}, '0);
    check("midrst_bus_error", bus_error, 1'b0);
    check_ahb_idle("midrst_ahb");
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    do_req(1'b0, '0, 26'h0003000, '0, 56'h9A, -1, 0, -1, 1, 16'h4444);

    // Randomized requests.
    for (int n = 0; n < 10; n++) begin
      for (int w = 0; w < 16; w++) begin
        d_rnd[32*w +: 32] = $urandom;
        be_rnd[4*w +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      t_rnd = {24'($urandom), 32'($urandom)};
      wb_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      eb_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      do_req(1'($urandom_range(0, 1)), be_rnd, 26'($urandom), d_rnd, t_rnd,
             wb_r, int'($urandom_range(0, 3)), eb_r, int'($urandom_range(0, 3)),
             16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
